ring_osc_ctrl: RTL and testbench
================================

Name: ring_osc_ctrl

Overview:
- Digital frequency controller that drives a ring-oscillator DCO's `enable_i` / `freq_sel_i` control inputs and observes its `clk_o` output.
- Counts DCO rising edges over a fixed window of the system clock, then binary-searches (SAR) the frequency-select code until the measured count matches a target.
- Optionally keeps tracking the target afterwards. Sits between the loop's target/config logic and the ring oscillator in the ADPLL.
- DCO frequency is monotonic in code: code 0 is the full ring (slowest); a higher code is a shorter ring (faster).

Parameters:
- CTRL_WIDTH, 5, width of the frequency-select code.
- CNT_WIDTH, 16, width of the edge counter, target and tolerance.
- WINDOW_CYCLES, 1000, `clk_i` cycles per measurement window (>=2).
- SETTLE_CYCLES, 16, `clk_i` cycles waited after any code change or enable before measuring (>=1).

Ports:
- clk_i  in  1  system clock; must be faster than 2x the DCO frequency.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; begins a SAR search from IDLE.
- stop_i  in  1  one-cycle pulse; aborts to IDLE from any state.
- target_count_i  in  CNT_WIDTH  desired DCO edge count per window; sampled on start_i.
- tolerance_i  in  CNT_WIDTH  tracking dead-band; sampled on start_i.
- dco_clk_i  in  1  DCO output; asynchronous to clk_i.
- dco_enable_o  out  1  drives the DCO enable.
- freq_sel_o  out  CTRL_WIDTH  drives the DCO frequency select.
- meas_count_o  out  CNT_WIDTH  last completed window count.
- meas_valid_o  out  1  one-cycle pulse when meas_count_o updates.
- busy_o  out  1  high in any state except IDLE.
- locked_o  out  1  high once the SAR search completes, until IDLE.
- err_o  out  1  sticky tracking-saturation flag.

Behaviour:
- Clock and reset: one clock, `clk_i`; reset is asynchronous and active-low (`rst_n_i`).
- Reset values: all outputs 0; state IDLE; bit index = CTRL_WIDTH-1.
- Edge detection: dco_clk_i passes through a 2-flop synchronizer plus one history flop. A rising edge is sync2 & ~hist.
  - Edges are counted only in MEASURE.
  - The counter clears on MEASURE entry and saturates at all-ones (no wrap).
- FSM states: IDLE, SETTLE, MEASURE, EVAL, LOCKED.
  - IDLE: dco_enable_o=0. On start_i:
    - latch target and tolerance;
    - set freq_sel_o = 1<<(CTRL_WIDTH-1), bit index = MSB;
    - clear err_o and locked_o;
    - dco_enable_o=1; go to SETTLE.
  - SETTLE: exactly SETTLE_CYCLES cycles, then MEASURE.
  - MEASURE: exactly WINDOW_CYCLES cycles, then EVAL.
  - EVAL (1 cycle):
    - meas_count_o <= count; meas_valid_o pulses in the following cycle.
    - In search: if count > target, clear the current trial bit.
    - If bit index > 0: set the next lower bit, decrement index, go to SETTLE.
    - Else: go to LOCKED and assert locked_o.
  - LOCKED:
    - With tracking compiled in: go straight to SETTLE and repeat the measure cycle. In tracking EVAL:
      - if count > target+tol, decrement code;
      - if count+tol < target, increment code;
      - both comparisons use CNT_WIDTH+1-bit arithmetic (no overflow);
      - if the required step would pass 0 or all-ones, hold the code and set err_o.
    - Without tracking: remain in LOCKED; code held; DCO stays enabled.
- Latency: one search step = SETTLE_CYCLES + WINDOW_CYCLES + 1 cycles. locked_o rises CTRL_WIDTH steps after start_i.
- start_i while busy_o=1 is ignored.
- stop_i has priority over start_i and over every transition. It forces IDLE next cycle: dco_enable_o=0, locked_o=0, freq_sel_o holds its last value, meas_count_o holds.
- Reset mid-operation: immediate asynchronous return to reset values.
- freq_sel_o changes only in the cycle after EVAL or on start_i; it is glitch-free (registered output).

Optional Feature:
- Macro: RING_OSC_CTRL_TRACK_EN.
- Defined: LOCKED continuously re-measures and steps the code by +/-1 per window outside the +/-tolerance band. err_o is as above.
- Undefined: LOCKED is terminal (until stop_i or reset), no measurements after lock, err_o is tied 0.

Decomposition:
- Package ring_osc_pkg holds:
  - the FSM state enum type;
  - default CTRL_WIDTH and CNT_WIDTH constants;
  - a function computing the SAR initial code.
- One sub-module, ring_osc_edge_counter: synchronizer, edge detect and saturating counter, with clear/enable inputs and a count output.

Test Plan:
- Bench setup: clk_i 100 MHz; WINDOW_CYCLES=1000; SETTLE_CYCLES=16; DCO model frequency = 5 MHz + code x 1 MHz.
- SAR search: target=200, tol=2; start_i pulse.
  - Required response: codes 16 -> 8 -> 12 -> 14 -> 15.
  - meas_count_o approx. 210, 130, 170, 190, 200 (+/-1).
  - locked_o high with freq_sel_o=15, 5x1017 cycles after start.
- Tracking (TRACK_EN): after lock, change the model offset to 6 MHz (count approx. 210).
  - Required response: code steps to 14 after the next window; locked_o stays 1; err_o=0.
- Saturation: target=40 (below the code-0 count of 50).
  - Required response: search ends at code 0.
  - With TRACK_EN: err_o=1 after the first tracking window, code stays 0.
- Abort: stop_i during MEASURE of the 3rd step.
  - Required response: next cycle IDLE, dco_enable_o=0, busy_o=0, locked_o=0, freq_sel_o held.
  - A start_i pulse issued while busy is ignored.
- Reset: assert rst_n_i=0 mid-SETTLE.
  - Required response: all outputs 0 immediately (asynchronously); after release, no activity until start_i.
- Counter saturation: CNT_WIDTH=4, DCO at 20 MHz.
  - Required response: meas_count_o=15 with no wrap.

Source files
------------

// File: rtl/ring_osc_pkg.sv
// ring_osc_pkg - shared types and helpers for the ring-oscillator frequency
// controller.
//   state_t         : controller FSM state encoding
//   CTRL_WIDTH_DEF  : default width of the DCO frequency-select code
//   CNT_WIDTH_DEF   : default width of the DCO edge counter / target / tolerance
//   sar_init_code() : first trial code of a binary search (MSB only)
`timescale 1ns/1ps
package ring_osc_pkg;

  localparam int CTRL_WIDTH_DEF = 5;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_EVAL    = 3'd3,
    ST_LOCKED  = 3'd4
  } state_t;

  // The search starts half-way up the code range: only the MSB set.
  function automatic logic [31:0] sar_init_code(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/ring_osc_edge_counter.sv
// ring_osc_edge_counter - counts rising edges of the free-running DCO clock
// in the system clock domain.
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   dco_clk  in   DCO output, asynchronous to clk
//   clear    in   synchronous clear of the count (wins over enable)
//   enable   in   count detected edges while high
//   count    out  edge count, saturates at all-ones
// The DCO must run below half the system clock rate so that every high and
// low phase is seen by at least one sample.
`timescale 1ns/1ps
module ring_osc_edge_counter
  import ring_osc_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dco_clk,
  input  logic                 clear,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] count
);

  logic                 sync1_reg;
  logic                 sync2_reg;
  logic                 hist_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 rise;

  // sync2 is the first metastability-safe copy; hist is its previous value.
  assign rise = sync2_reg & ~hist_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      hist_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      sync1_reg <= dco_clk;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
      if (clear) begin
        count_reg <= '0;
      end else if (enable && rise && (count_reg != '1)) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/ring_osc_ctrl.sv
// ring_osc_ctrl - digital frequency controller for a ring-oscillator DCO.
// Measures DCO edges over a fixed window and binary-searches the
// frequency-select code until the count meets the target; optionally keeps
// tracking the target with +/-1 code steps once locked.
//   clk_i / rst_n_i   system clock, asynchronous active-low reset
//   start_i           pulse: begin a search (only from IDLE)
//   stop_i            pulse: abort to IDLE from any state (highest priority)
//   target_count_i    desired edges per window, sampled on start_i
//   tolerance_i       tracking dead-band, sampled on start_i
//   dco_clk_i         DCO output (asynchronous)
//   dco_enable_o      DCO enable
//   freq_sel_o        DCO frequency select (registered)
//   meas_count_o      last completed window count
//   meas_valid_o      one-cycle pulse when meas_count_o updates
//   busy_o            high outside IDLE
//   locked_o          high from search completion until IDLE
//   err_o             sticky tracking-saturation flag
// Build option: define RING_OSC_CTRL_TRACK_EN to keep tracking after lock;
// without it LOCKED is terminal and err_o is constant 0.
`timescale 1ns/1ps
module ring_osc_ctrl
  import ring_osc_pkg::*;
#(
  parameter int CTRL_WIDTH    = CTRL_WIDTH_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF,
  parameter int WINDOW_CYCLES = 1000,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [CNT_WIDTH-1:0]  target_count_i,
  input  logic [CNT_WIDTH-1:0]  tolerance_i,
  input  logic                  dco_clk_i,
  output logic                  dco_enable_o,
  output logic [CTRL_WIDTH-1:0] freq_sel_o,
  output logic [CNT_WIDTH-1:0]  meas_count_o,
  output logic                  meas_valid_o,
  output logic                  busy_o,
  output logic                  locked_o,
  output logic                  err_o
);

  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int IDX_W   = (CTRL_WIDTH > 1) ? $clog2(CTRL_WIDTH) : 1;

  localparam logic [TMR_W-1:0]      SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]      WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CTRL_WIDTH-1:0] CODE_INIT   = CTRL_WIDTH'(sar_init_code(CTRL_WIDTH));
  localparam logic [IDX_W-1:0]      IDX_MSB     = IDX_W'(CTRL_WIDTH - 1);

  state_t                state_reg,  state_next;
  logic [TMR_W-1:0]      tmr_reg,    tmr_next;
  logic [CTRL_WIDTH-1:0] code_reg,   code_next;
  logic [IDX_W-1:0]      idx_reg,    idx_next;
  logic [CNT_WIDTH-1:0]  target_reg, target_next;
  logic [CNT_WIDTH-1:0]  meas_reg,   meas_next;
  logic                  valid_reg,  valid_next;
  logic                  locked_reg, locked_next;
  logic [CNT_WIDTH-1:0]  cnt;

  // Counter is held at zero through SETTLE, so it is clean on MEASURE entry.
  ring_osc_edge_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_edge_counter (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .dco_clk (dco_clk_i),
    .clear   (state_reg == ST_SETTLE),
    .enable  (state_reg == ST_MEASURE),
    .count   (cnt)
  );

`ifdef RING_OSC_CTRL_TRACK_EN
  logic [CNT_WIDTH-1:0] tol_reg, tol_next;
  logic                 err_reg, err_next;
  logic [CNT_WIDTH:0]   cnt_ext, tgt_ext, hi_bound, cnt_plus_tol;

  // One extra bit so target+tol and count+tol never wrap.
  assign cnt_ext      = {1'b0, cnt};
  assign tgt_ext      = {1'b0, target_reg};
  assign hi_bound     = {1'b0, target_reg} + {1'b0, tol_reg};
  assign cnt_plus_tol = {1'b0, cnt} + {1'b0, tol_reg};
`else
  logic unused_tol;
  assign unused_tol = ^tolerance_i;
`endif

  always_comb begin
    state_next  = state_reg;
    tmr_next    = tmr_reg;
    code_next   = code_reg;
    idx_next    = idx_reg;
    target_next = target_reg;
    meas_next   = meas_reg;
    valid_next  = 1'b0;
    locked_next = locked_reg;
`ifdef RING_OSC_CTRL_TRACK_EN
    tol_next    = tol_reg;
    err_next    = err_reg;
`endif
    if (stop_i) begin
      // Code and last measurement are deliberately kept for inspection.
      state_next  = ST_IDLE;
      tmr_next    = '0;
      locked_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            target_next = target_count_i;
            code_next   = CODE_INIT;
            idx_next    = IDX_MSB;
            locked_next = 1'b0;
            tmr_next    = '0;
            state_next  = ST_SETTLE;
`ifdef RING_OSC_CTRL_TRACK_EN
            tol_next    = tolerance_i;
            err_next    = 1'b0;
`endif
          end
        end
        ST_SETTLE: begin
          if (tmr_reg == SETTLE_LAST) begin
            tmr_next   = '0;
            state_next = ST_MEASURE;
          end else begin
            tmr_next = tmr_reg + 1'b1;
          end
        end
        ST_MEASURE: begin
          if (tmr_reg == WINDOW_LAST) begin
            tmr_next   = '0;
            state_next = ST_EVAL;
          end else begin
            tmr_next = tmr_reg + 1'b1;
          end
        end
        ST_EVAL: begin
          meas_next  = cnt;
          valid_next = 1'b1;
`ifdef RING_OSC_CTRL_TRACK_EN
          if (locked_reg) begin
            // Tracking: single-step toward the band; refuse to wrap the code.
            if (cnt_ext > hi_bound) begin
              if (code_reg == '0) err_next = 1'b1;
              else                code_next = code_reg - 1'b1;
            end else if (cnt_plus_tol < tgt_ext) begin
              if (code_reg == '1) err_next = 1'b1;
              else                code_next = code_reg + 1'b1;
            end
            state_next = ST_LOCKED;
          end else
`endif
          begin
            // Search: too fast means the trial bit overshot, so drop it.
            if (cnt > target_reg) code_next[idx_reg] = 1'b0;
            if (idx_reg != '0) begin
              code_next[idx_reg - 1'b1] = 1'b1;
              idx_next   = idx_reg - 1'b1;
              state_next = ST_SETTLE;
            end else begin
              locked_next = 1'b1;
              state_next  = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
`ifdef RING_OSC_CTRL_TRACK_EN
          state_next = ST_SETTLE;
`endif
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg  <= ST_IDLE;
      tmr_reg    <= '0;
      code_reg   <= '0;
      idx_reg    <= IDX_MSB;
      target_reg <= '0;
      meas_reg   <= '0;
      valid_reg  <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tmr_reg    <= tmr_next;
      code_reg   <= code_next;
      idx_reg    <= idx_next;
      target_reg <= target_next;
      meas_reg   <= meas_next;
      valid_reg  <= valid_next;
      locked_reg <= locked_next;
    end
  end

`ifdef RING_OSC_CTRL_TRACK_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tol_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      tol_reg <= tol_next;
      err_reg <= err_next;
    end
  end
  assign err_o = err_reg;
`else
  assign err_o = 1'b0;
`endif

  assign dco_enable_o = (state_reg != ST_IDLE);
  assign busy_o       = (state_reg != ST_IDLE);
  assign freq_sel_o   = code_reg;
  assign meas_count_o = meas_reg;
  assign meas_valid_o = valid_reg;
  assign locked_o     = locked_reg;

endmodule

// File: tb/tb_ring_osc_ctrl.sv
// tb_ring_osc_ctrl - scoreboard bench for ring_osc_ctrl.
// A behavioural DCO runs at (offset + code) MHz; expected window counts and
// post-evaluation codes are pushed when a search starts and popped on every
// meas_valid_o pulse. A second instance with a 4-bit counter covers counter
// saturation. Honours RING_OSC_CTRL_TRACK_EN for the tracking checks.
`timescale 1ns/1ps
module tb_ring_osc_ctrl;

  localparam int CW     = 5;
  localparam int NW     = 16;
  localparam int WINDOW = 1000;
  localparam int SETTLE = 16;
  localparam int STEP   = SETTLE + WINDOW + 1;
  localparam int NW4    = 4;
  localparam int SAT4   = (1 << NW4) - 1;

  typedef struct {
    int cnt;
    int code;
  } exp_t;

  logic          clk, rst_n, start, stop;
  logic [NW-1:0] target, tol;
  logic          dco_clk, dco_en, meas_valid, busy, locked, err;
  logic [CW-1:0] freq_sel;
  logic [NW-1:0] meas_count;

  logic           start4, dco_clk4, dco_en4, meas_valid4, busy4, locked4, err4;
  logic [NW4-1:0] meas_count4;
  logic [CW-1:0]  freq_sel4;

  int   n_checks = 0;
  int   n_errors = 0;
  int   offset   = 5;
  exp_t sb_q[$];
  real  half_ns;

  ring_osc_ctrl #(.CTRL_WIDTH(CW), .CNT_WIDTH(NW), .WINDOW_CYCLES(WINDOW), .SETTLE_CYCLES(SETTLE)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop),
    .target_count_i(target), .tolerance_i(tol), .dco_clk_i(dco_clk),
    .dco_enable_o(dco_en), .freq_sel_o(freq_sel), .meas_count_o(meas_count),
    .meas_valid_o(meas_valid), .busy_o(busy), .locked_o(locked), .err_o(err)
  );

  ring_osc_ctrl #(.CTRL_WIDTH(CW), .CNT_WIDTH(NW4), .WINDOW_CYCLES(100), .SETTLE_CYCLES(SETTLE)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start4), .stop_i(1'b0),
    .target_count_i(4'd15), .tolerance_i(4'd0), .dco_clk_i(dco_clk4),
    .dco_enable_o(dco_en4), .freq_sel_o(freq_sel4), .meas_count_o(meas_count4),
    .meas_valid_o(meas_valid4), .busy_o(busy4), .locked_o(locked4), .err_o(err4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DCO model: (offset + code) MHz, started off the system clock grid.
  initial begin
    dco_clk = 1'b0;
    #1.3;
    forever begin
      half_ns = 500.0 / real'(offset + int'(freq_sel));
      #(half_ns);
      if (dco_en) dco_clk = ~dco_clk;
      else        dco_clk = 1'b0;
    end
  end

  // Fixed 20 MHz DCO for the 4-bit counter instance.
  initial begin
    dco_clk4 = 1'b0;
    #2.1;
    forever begin
      #25;
      if (dco_en4) dco_clk4 = ~dco_clk4;
      else         dco_clk4 = 1'b0;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Window counts depend on DCO phase, so allow +/-1 edge.
  function automatic int near(input int obs, input int exp);
    return ((obs >= exp - 1) && (obs <= exp + 1)) ? exp : obs;
  endfunction

  function automatic int model_count(input int code);
    return (offset + code) * WINDOW / 100;
  endfunction

  function automatic int outs1();
    return int'({dco_en, freq_sel, meas_count, meas_valid, busy, locked, err});
  endfunction

  // Reference binary search; pushes one expectation per window.
  function automatic int model_sar(input int tgt);
    exp_t e;
    int   code;
    code = 1 << (CW - 1);
    for (int b = CW - 1; b >= 0; b--) begin
      e.cnt = model_count(code);
      if (e.cnt > tgt) code = code & ~(1 << b);
      if (b > 0) code = code | (1 << (b - 1));
      e.code = code;
      sb_q.push_back(e);
    end
    return code;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (meas_valid) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("meas: count=%0d (model %0d) code=%0d (model %0d) locked=%0d err=%0d",
                 meas_count, e.cnt, freq_sel, e.code, locked, err);
        check("meas_count", near(int'(meas_count), e.cnt), e.cnt);
        check("meas_code", int'(freq_sel), e.code);
      end else begin
        $display("meas: count=%0d code=%0d (no expectation) locked=%0d", meas_count, freq_sel, locked);
`ifdef RING_OSC_CTRL_TRACK_EN
        if (!locked) check("unexp_valid", int'(meas_valid), 0);
`else
        check("unexp_valid", int'(meas_valid), 0);
`endif
      end
    end
  end

  task automatic pulse_stop();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    check("sb_drain", sb_q.size(), 0);
  endtask

  // Start a search and check lock timing exactly CW steps after start.
  task automatic run_search(input int tgt, input int tl);
    int final_code;
    final_code = model_sar(tgt);
    @(negedge clk);
    target = NW'(tgt);
    tol    = NW'(tl);
    start  = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (CW * STEP - 1) @(posedge clk);
    #1 check("locked_early", int'(locked), 0);
    @(posedge clk);
    #1;
    $display("lock: target=%0d code=%0d locked=%0d busy=%0d", tgt, freq_sel, locked, busy);
    check("locked", int'(locked), 1);
    check("lock_code", int'(freq_sel), final_code);
    check("busy_locked", int'(busy), 1);
  endtask

  initial begin
    exp_t e;
    int   got;
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    start4 = 1'b0;
    target = '0;
    tol    = '0;

    repeat (3) @(posedge clk);
    #1;
    $display("reset: outs=%0h", outs1());
    check("reset_outs", outs1(), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Search to 200 edges: 16 -> 8 -> 12 -> 14 -> 15.
    run_search(200, 2);
`ifdef RING_OSC_CTRL_TRACK_EN
    offset = 6;
    e.cnt = 210; e.code = 14; sb_q.push_back(e);
    e.cnt = 200; e.code = 14; sb_q.push_back(e);
    wait_drain(3 * STEP);
    check("track_code", int'(freq_sel), 14);
    check("track_locked", int'(locked), 1);
    check("track_err", int'(err), 0);
`else
    repeat (2 * STEP) @(posedge clk);
    #1;
    check("hold_code", int'(freq_sel), 15);
    check("hold_locked", int'(locked), 1);
    check("hold_enable", int'(dco_en), 1);
`endif
    pulse_stop();
    check("stop_busy", int'(busy), 0);
    offset = 5;
    wait_drain(10);

    // Target below the slowest code: search bottoms out at 0.
    run_search(40, 2);
`ifdef RING_OSC_CTRL_TRACK_EN
    e.cnt = 50; e.code = 0; sb_q.push_back(e);
    wait_drain(2 * STEP);
    check("sat_err", int'(err), 1);
    check("sat_code", int'(freq_sel), 0);
`else
    repeat (STEP + 100) @(posedge clk);
    #1;
    check("sat_err", int'(err), 0);
    check("sat_code", int'(freq_sel), 0);
`endif
    pulse_stop();
    wait_drain(10);

    // Abort during MEASURE of the third step; a start while busy is ignored.
    void'(model_sar(200));
    @(negedge clk);
    target = 16'd200;
    tol    = 16'd2;
    start  = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 2 * STEP + 100 && sb_q.size() > 3; i++) @(posedge clk);
    #2 check("abort_reach", sb_q.size(), 3);
    repeat (200) @(posedge clk);
    @(negedge clk);
    target = 16'd40;
    start  = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (50) @(posedge clk);
    pulse_stop();
    $display("abort: busy=%0d en=%0d locked=%0d code=%0d count=%0d", busy, dco_en, locked, freq_sel, meas_count);
    check("abort_busy", int'(busy), 0);
    check("abort_enable", int'(dco_en), 0);
    check("abort_locked", int'(locked), 0);
    check("abort_code", int'(freq_sel), 12);
    check("abort_count", near(int'(meas_count), model_count(8)), model_count(8));
    sb_q.delete();
    repeat (2 * STEP) @(posedge clk);
    #1;
    check("abort_idle", int'(busy), 0);
    check("abort_code_held", int'(freq_sel), 12);

    // Asynchronous reset in the middle of SETTLE.
    @(negedge clk);
    target = 16'd200;
    start  = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("async reset: outs=%0h", outs1());
    check("rst_async_outs", outs1(), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2 * STEP) @(posedge clk);
    #1;
    check("rst_quiet_outs", outs1(), 0);

    // 4-bit counter against a 20-edge window: must pin at all-ones.
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (meas_valid4) begin
        got = 1;
        break;
      end
    end
    $display("cnt4: valid=%0d count=%0d code=%0d en=%0d busy=%0d locked=%0d err=%0d",
             got, meas_count4, freq_sel4, dco_en4, busy4, locked4, err4);
    check("cnt4_valid", got, 1);
    check("cnt4_sat", int'(meas_count4), SAT4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
